// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequential signed multiply-accumulate over N_TERMS handshake beats
// Optional: MAC_SEQ_ALLOW_RESTART_EN lets start restart an accumulation in progress.
module mac_seq #(
    parameter int DATA_W   = 4,
    parameter int WEIGHT_W = 4,
    parameter int N_TERMS  = 3,
    parameter int ACC_W    = DATA_W + WEIGHT_W + $clog2(N_TERMS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   data,
    input  logic [WEIGHT_W-1:0] weight,
    output logic [ACC_W-1:0]    S,
    output logic                done,
    output logic                busy
);

    localparam int P_W   = DATA_W + WEIGHT_W;
    // keep the counter at least one bit wide so N_TERMS=1 still elaborates
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_W-1:0]       acc;
    logic [CNT_W-1:0]       count;
    logic                   beat;
    logic                   restart;
    logic signed [P_W-1:0]  prod;
    logic [ACC_W-1:0]       sum;

    assign prod = P_W'($signed(data)) * P_W'($signed(weight));
    assign sum  = acc + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        beat      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
`ifdef MAC_SEQ_ALLOW_RESTART_EN
                restart  = start;
`else
                restart  = 1'b0;
`endif
                // a restart discards whatever pair is offered in the same cycle
                beat = in_valid && !restart;
                if (beat && (count == LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // S is loaded on the final beat so it is already valid during the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            S     <= '0;
        end else if (((state == IDLE) && start) || restart) begin
            acc   <= '0;
            count <= '0;
        end else if (beat) begin
            acc   <= sum;
            count <= count + CNT_W'(1);
            if (count == LAST) begin
                S <= sum;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - self-checking bench for mac_seq against a sum-of-products model
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, in_ready, done, busy;
    logic [3:0]  data, weight;
    logic [9:0]  S;

    logic        start1, in_valid1, one_ready, one_done, one_busy;
    logic [8:0]  one_S;

    logic        startw, in_validw, w_ready, w_done, w_busy;
    logic [7:0]  dataw, weightw;
    logic [19:0] w_S;

    int checks   = 0;
    int failures = 0;
    int pd[8];
    int pw[8];
    int s_prev   = 0;

    always #5 clk = ~clk;

    mac_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .weight(weight), .S(S), .done(done), .busy(busy)
    );

    mac_seq #(.N_TERMS(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_ready(one_ready),
        .data(data), .weight(weight), .S(one_S), .done(one_done), .busy(one_busy)
    );

    mac_seq #(.DATA_W(8), .WEIGHT_W(8), .N_TERMS(8)) u_wide (
        .clk(clk), .rst_n(rst_n), .start(startw), .in_valid(in_validw), .in_ready(w_ready),
        .data(dataw), .weight(weightw), .S(w_S), .done(w_done), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // stall < 0 picks a random 0..2 idle cycles between beats
    task automatic run(input int n, input int stall, input string tag);
        int exp;
        int ns;
        exp = 0;
        start = 1'b1; in_valid = 1'b1; data = 4'(pd[0]); weight = 4'(pw[0]);
        tick;
        start = 1'b0; in_valid = 1'b0;
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; data = 4'(pd[i]); weight = 4'(pw[i]);
            exp += pd[i] * pw[i];
            tick;
            in_valid = 1'b0;
            if (i < n - 1) begin
                chk({tag, "_nodone"}, done, 0);
                chk({tag, "_hold"}, $signed(S), s_prev);
                ns = (stall < 0) ? int'($urandom_range(2, 0)) : stall;
                for (int k = 0; k < ns; k++) begin
                    tick;
                    chk({tag, "_stall_ready"}, in_ready, 1);
                    chk({tag, "_stall_done"}, done, 0);
                end
            end else begin
                chk({tag, "_done"}, done, 1);
                chk({tag, "_S"}, $signed(S), exp);
                chk({tag, "_busy_done"}, busy, 0);
            end
        end
        tick;
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_S_held"}, $signed(S), exp);
        s_prev = exp;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; data = '0; weight = '0;
        start1 = 1'b0; in_valid1 = 1'b0; startw = 1'b0; in_validw = 1'b0;
        dataw = '0; weightw = '0;
        tick; tick;
        chk("rst_S", $signed(S), 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_wide_S", $signed(w_S), 0);
        rst_n = 1'b1;
        tick;
        chk("idle_ready", in_ready, 0);

        pd[0] = 2;  pw[0] = 2;  pd[1] = -3; pw[1] = 3;  pd[2] = 1;  pw[2] = -4;
        run(3, 0, "b2b");
        pd[0] = -8; pw[0] = 1;  pd[1] = 7;  pw[1] = -2; pd[2] = -2; pw[2] = 3;
        run(3, 2, "stall");
        for (int i = 0; i < 3; i++) begin pd[i] = 5; pw[i] = -1; end
        run(3, 0, "neg15");
        for (int i = 0; i < 3; i++) begin pd[i] = 4; pw[i] = 4; end
        run(3, 0, "pos48");
        for (int i = 0; i < 3; i++) begin pd[i] = -8; pw[i] = -8; end
        run(3, 0, "extreme");

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 3; i++) begin
                pd[i] = int'($urandom_range(15, 0)) - 8;
                pw[i] = int'($urandom_range(15, 0)) - 8;
            end
            run(3, -1, "rand");
        end

        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; data = 4'(5); weight = 4'(3); tick;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_S", $signed(S), 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_done", done, 0);
        #2;
        rst_n = 1'b1;
        tick;
        s_prev = 0;
        for (int i = 0; i < 3; i++) begin pd[i] = 1; pw[i] = 1; end
        run(3, 0, "after_rst");

        start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1; data = 4'(7); weight = 4'(7); tick;
        in_valid = 1'b0;
        start = 1'b1; tick; start = 1'b0;
`ifdef MAC_SEQ_ALLOW_RESTART_EN
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; data = 4'(1); weight = 4'(1); tick;
        end
        in_valid = 1'b0;
        chk("restart_done", done, 1);
        chk("restart_S", $signed(S), 3);
        tick;
        s_prev = 3;
`else
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; data = 4'(1); weight = 4'(1); tick;
        end
        chk("norestart_done", done, 1);
        chk("norestart_S", $signed(S), 51);
        tick;
        in_valid = 1'b0;
        chk("norestart_idle_ready", in_ready, 0);
        chk("norestart_idle_busy", busy, 0);
        chk("norestart_S_held", $signed(S), 51);
        s_prev = 51;
`endif

        start1 = 1'b1; tick; start1 = 1'b0;
        chk("one_ready", one_ready, 1);
        in_valid1 = 1'b1; data = 4'(-3); weight = 4'(5); tick;
        in_valid1 = 1'b0;
        chk("one_done", one_done, 1);
        chk("one_S", $signed(one_S), -15);
        tick;
        chk("one_done_clr", one_done, 0);
        chk("one_busy", one_busy, 0);

        startw = 1'b1; tick; startw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_validw = 1'b1; dataw = 8'(-128); weightw = 8'(-128); tick;
            if (i < 7) chk("wide_nodone", w_done, 0);
        end
        in_validw = 1'b0;
        chk("wide_done", w_done, 1);
        chk("wide_S", $signed(w_S), 131072);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
